// File: rtl/out_uart_pkg.sv
// -----------------------------------------------------------------------------
// out_uart_pkg
// Shared definitions for the output-byte UART transmitter:
//   - tx_state_e : transmit FSM states (IDLE, START, DATA, STOP)
//   - DATA_BITS / STOP_BITS / FRAME_BITS : 8N1 frame shape
// No ports (package).
// -----------------------------------------------------------------------------
package out_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
// A push while full is accepted only when a pop happens at the same edge.
// A pop while empty is ignored.
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset (empties the FIFO)
//   push_i     in   write data_i at this edge
//   data_i     in   WIDTH-bit write data
//   pop_i      in   remove the head entry at this edge
//   rd_data_o  out  current head entry (valid when not empty)
//   full_o     out  occupancy == DEPTH
//   empty_o    out  occupancy == 0
//   count_o    out  current occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign do_pop    = pop_i && !empty_o;
  // Full FIFO still takes a byte when the head leaves at the same edge.
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/out_uart_tx.sv
// -----------------------------------------------------------------------------
// out_uart_tx
// Watches a byte bus and transmits every new value on an 8N1 UART line.
// A byte is captured whenever data_i differs from the last captured byte;
// captured bytes queue in a FIFO and are sent LSB first.
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous active-high reset; aborts any frame
//   data_i        in   monitored byte
//   tx_o          out  serial line, idle high, registered
//   busy_o        out  frame in flight or FIFO non-empty
//   overflow_o    out  sticky: a captured byte was dropped on a full FIFO
//   fifo_count_o  out  FIFO occupancy
// -----------------------------------------------------------------------------
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [7:0]                         data_i,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic                               overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count_o
);

  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        last_q;

  logic              push_req;
  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_done;

  assign push_req  = (data_i != last_q);
  assign baud_done = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push_req),
    .data_i    (data_i),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count_o)
  );

  // Next-state, baud/bit counters, FIFO pop and next serial bit.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    tx_d       = 1'b1;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        baud_d = BAUD_W'(0);
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_W'(0);
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = BAUD_W'(0);
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = BAUD_W'(0);
          state_d = IDLE;
        end else begin
          baud_d  = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = BAUD_W'(0);
        state_d = IDLE;
      end
    endcase

    // Line level is derived from the next state so tx_q changes on the
    // same edge as the state register and never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase

    // A drop happens only when full and the head is not leaving this edge.
    if (push_req && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, counters, line and capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baud_q     <= BAUD_W'(0);
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      if (push_req) begin
        last_q   <= data_i;
      end
    end
  end

  assign tx_o       = tx_q;
  assign overflow_o = overflow_q;
  assign busy_o     = (state_q != IDLE) || (fifo_count_o != '0);

endmodule

// File: tb/tb_out_uart_tx.sv
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int HALF  = CPB / 2;

  logic       clk;
  logic       rst_i;
  logic [7:0] data_i;
  logic       tx_o;
  logic       busy_o;
  logic       overflow_o;
  logic [2:0] fifo_count_o;

  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .fifo_count_o (fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // Reference model: byte queue, frame timer counting down the cycles left
  // in the frame on the line, and the byte being sent.
  logic [7:0] m_last;
  logic [7:0] m_fifo[$];
  int         m_timer;
  logic [7:0] m_byte;
  logic       m_ovf;
  logic [7:0] exp_q[$];
  int         frames_rx = 0;
  int         peak;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] d, input logic r);
    bit pop;
    int pre;
    if (r) begin
      m_last = 8'h00; m_fifo.delete(); m_timer = 0; m_ovf = 1'b0; exp_q.delete();
    end else begin
      pre = m_fifo.size();
      pop = (m_timer == 0) && (pre > 0);
      if (pop) begin
        m_byte  = m_fifo.pop_front();
        m_timer = FRAME;
      end else if (m_timer > 0) begin
        m_timer--;
      end
      if (d != m_last) begin
        m_last = d;
        if (pre < DEPTH || pop) begin
          m_fifo.push_back(d);
          exp_q.push_back(d);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int p, slot;
    logic etx;
    if (m_timer == 0) etx = 1'b1;
    else begin
      p = FRAME - m_timer;
      slot = p / CPB;
      if (slot == 0) etx = 1'b0;
      else if (slot <= 8) etx = m_byte[slot-1];
      else etx = 1'b1;
    end
    chk("tx_o", int'(tx_o), int'(etx));
    chk("busy_o", int'(busy_o), int'((m_timer != 0) || (m_fifo.size() != 0)));
    chk("fifo_count_o", int'(fifo_count_o), m_fifo.size());
    chk("overflow_o", int'(overflow_o), int'(m_ovf));
  endtask

  task automatic step(input logic [7:0] d, input logic r);
    data_i = d;
    rst_i  = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    check_outputs();
    if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(data_i, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_timer != 0 || m_fifo.size() != 0) && guard < 2000) begin
      step(data_i, 1'b0);
      guard++;
    end
    chk("drain_timeout", int'(guard < 2000), 1);
    hold(4);
  endtask

  // UART receiver: samples mid-bit on the falling clock edge and checks each
  // completed frame against the head of the expected-byte queue.
  bit         mon_on = 1'b0;
  int         mon_t;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx_o === 1'b0) begin
        mon_on = 1'b1;
        mon_t  = 0;
      end
    end else begin
      mon_t++;
      if (mon_t == HALF) begin
        chk("start_bit", int'(tx_o), 0);
      end else if (mon_t > HALF && (mon_t - HALF) % CPB == 0 && (mon_t - HALF) / CPB <= 8) begin
        mon_byte[(mon_t - HALF) / CPB - 1] = tx_o;
      end else if (mon_t == HALF + 9 * CPB) begin
        chk("stop_bit", int'(tx_o), 1);
        vec++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL frame: got unexpected byte %0h expected none", mon_byte);
        end else if (mon_byte !== exp_q[0]) begin
          miss++;
          $display("FAIL frame: got %0h expected %0h", mon_byte, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        frames_rx++;
        mon_on = 1'b0;
      end
    end
  end

  initial begin
    int f0;
    logic [7:0] cur;
    m_last = 8'h00; m_timer = 0; m_ovf = 1'b0; m_byte = 8'h00;
    data_i = 8'h00; rst_i = 1'b1;

    // Reset, then a constant 0x00 must not start a frame.
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    chk("reset_tx", int'(tx_o), 1);
    chk("reset_count", int'(fifo_count_o), 0);
    f0 = frames_rx;
    hold(60);
    chk("zero_after_reset_frames", frames_rx - f0, 0);

    // Single byte 0x41 held for 200 cycles: exactly one frame.
    f0 = frames_rx;
    step(8'h41, 1'b0);
    hold(200);
    chk("hold_41_frames", frames_rx - f0, 1);

    // 0x41 then 0x00: second frame carries 0x00.
    f0 = frames_rx;
    step(8'h00, 1'b0);
    drain();
    chk("zero_frame", frames_rx - f0, 1);

    // Five values on consecutive edges: all sent, peak occupancy 4.
    peak = 0;
    f0 = frames_rx;
    for (int i = 0; i < 5; i++) step(8'h21 + 8'(i), 1'b0);
    drain();
    chk("five_frames", frames_rx - f0, 5);
    chk("five_peak", peak, 4);
    chk("five_ovf", int'(overflow_o), 0);

    // Six values on consecutive edges: five sent, sixth dropped, sticky flag.
    f0 = frames_rx;
    for (int i = 0; i < 6; i++) step(8'h10 + 8'(i), 1'b0);
    drain();
    chk("six_frames", frames_rx - f0, 5);
    chk("six_ovf", int'(overflow_o), 1);
    hold(20);
    chk("six_ovf_sticky", int'(overflow_o), 1);

    // Reset during the data bits of 0x55 with two bytes queued.
    step(8'h00, 1'b1);
    step(8'h55, 1'b0);
    step(8'h66, 1'b0);
    step(8'h77, 1'b0);
    hold(8);
    f0 = frames_rx;
    step(8'h00, 1'b1);
    chk("abort_tx", int'(tx_o), 1);
    chk("abort_count", int'(fifo_count_o), 0);
    hold(100);
    chk("abort_frames", frames_rx - f0, 0);

    // Randomized traffic with occasional bursts and resets.
    cur = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        step(8'h00, 1'b1);
        cur = 8'h00;
      end else if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 6; j++) begin
          cur = 8'($urandom);
          step(cur, 1'b0);
        end
      end else begin
        if ($urandom_range(0, 24) == 0) cur = 8'($urandom);
        step(cur, 1'b0);
      end
    end
    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
